// File: rtl/four_bit_max_tracker.sv
// Frame statistics stage: tracks max, min, max-occurrence count and sample count
// over a valid/ready sample stream, and presents the result on a held valid/ready output.

module four_bit_comparator (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic       o_gt,
  output logic       o_eq,
  output logic       o_lt
);
  assign o_gt = (i_x > i_y);
  assign o_eq = (i_x == i_y);
  assign o_lt = (i_x < i_y);
endmodule

module four_bit_max_tracker #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       max_out,
  output logic [3:0]       min_out,
  output logic [CNT_W-1:0] max_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // in_ready depends only on the state register, so input and output transfers never coincide.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_max;
  logic [3:0]       r_min;
  logic [CNT_W-1:0] r_max_cnt;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [3:0]       w_max_nx;
  logic [3:0]       w_min_nx;
  logic [CNT_W-1:0] w_max_cnt_nx;
  logic [CNT_W-1:0] w_smp_cnt_nx;

  logic w_accept;
  logic w_a_gt, w_a_eq, w_a_lt;
  logic w_b_gt, w_b_eq, w_b_lt;

  // A: is the new sample above the current max?  B: is the current min above the new sample?
  four_bit_comparator u_cmp_max (
    .i_x (in_data),
    .i_y (r_max),
    .o_gt(w_a_gt),
    .o_eq(w_a_eq),
    .o_lt(w_a_lt)
  );

  four_bit_comparator u_cmp_min (
    .i_x (r_min),
    .i_y (in_data),
    .o_gt(w_b_gt),
    .o_eq(w_b_eq),
    .o_lt(w_b_lt)
  );

  assign in_ready     = (r_state != S_HOLD);
  assign out_valid    = (r_state == S_HOLD);
  assign w_accept     = in_valid & in_ready;
  assign max_out      = r_max;
  assign min_out      = r_min;
  assign max_count    = r_max_cnt;
  assign sample_count = r_smp_cnt;
  assign dbg_state    = r_state;

  always_comb begin
    w_next_state = r_state;
    w_max_nx     = r_max;
    w_min_nx     = r_min;
    w_max_cnt_nx = r_max_cnt;
    w_smp_cnt_nx = r_smp_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_max_nx     = in_data;
          w_min_nx     = in_data;
          w_max_cnt_nx = CNT_ONE;
          w_smp_cnt_nx = CNT_ONE;
          w_next_state = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (w_a_gt) begin
            w_max_nx     = in_data;
            w_max_cnt_nx = CNT_ONE;
          end else if (w_a_eq && (r_max_cnt != CNT_MAX)) begin
            w_max_cnt_nx = r_max_cnt + CNT_ONE;
          end
          if (w_b_gt) begin
            w_min_nx = in_data;
          end
          if (r_smp_cnt != CNT_MAX) begin
            w_smp_cnt_nx = r_smp_cnt + CNT_ONE;
          end
          if (in_last) begin
            w_next_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_max     <= 4'd0;
      r_min     <= 4'd0;
      r_max_cnt <= '0;
      r_smp_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_max     <= w_max_nx;
      r_min     <= w_min_nx;
      r_max_cnt <= w_max_cnt_nx;
      r_smp_cnt <= w_smp_cnt_nx;
    end
  end

endmodule

// File: tb/tb_four_bit_max_tracker.sv
// Directed bench for four_bit_max_tracker: a table of whole frames with hand-computed
// results, plus hand-written back-pressure, saturation-free gap and reset sequences.

module tb_four_bit_max_tracker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] max_out;
  logic [3:0] min_out;
  logic [3:0] max_count;
  logic [3:0] sample_count;
  logic [1:0] dbg_state;

  int total;
  int bad;

  four_bit_max_tracker #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .max_out     (max_out),
    .min_out     (min_out),
    .max_count   (max_count),
    .sample_count(sample_count),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples packed low-nibble-first: sample i lives in bits [4*i+3 : 4*i].
  typedef struct {
    string       name;
    int          n;
    logic [79:0] samples;
    logic [3:0]  exp_max;
    logic [3:0]  exp_min;
    logic [3:0]  exp_mcnt;
    logic [3:0]  exp_scnt;
  } frame_t;

  frame_t frames [6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait (bounded) for it to be accepted.
  task automatic send(input logic [3:0] d, input logic last);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [3:0] emax, input logic [3:0] emin,
                              input logic [3:0] emc, input logic [3:0] esc);
    check({name, "_out_valid"}, int'(out_valid), 1);
    check({name, "_in_ready"}, int'(in_ready), 0);
    check({name, "_max"}, int'(max_out), int'(emax));
    check({name, "_min"}, int'(min_out), int'(emin));
    check({name, "_max_count"}, int'(max_count), int'(emc));
    check({name, "_sample_count"}, int'(sample_count), int'(esc));
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, int'(out_valid), 0);
    check({name, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    frames[0] = '{"basic",   5, 80'h79295,               4'd9,  4'd2,  4'd2,  4'd5};
    frames[1] = '{"single",  1, 80'hA,                   4'd10, 4'd10, 4'd1,  4'd1};
    frames[2] = '{"sat",    20, {20{4'hF}},              4'd15, 4'd15, 4'd15, 4'd15};
    frames[3] = '{"bound_a", 4, 80'hF0F0,                4'd15, 4'd0,  4'd2,  4'd4};
    frames[4] = '{"bound_b", 3, 80'h213,                 4'd3,  4'd1,  4'd1,  4'd3};
    frames[5] = '{"mixed",   6, 80'h188822,              4'd8,  4'd1,  4'd3,  4'd6};

    // Reset state, with in_valid asserted to show nothing is taken under reset.
    #2;
    in_valid = 1'b1;
    in_data  = 4'd9;
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_max", int'(max_out), 0);
    check("rst_min", int'(min_out), 0);
    check("rst_max_count", int'(max_count), 0);
    check("rst_sample_count", int'(sample_count), 0);
    check("rst_state", int'(dbg_state), 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();

    // Table of frames.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < frames[f].n; i++) begin
        logic [79:0] s;
        s = frames[f].samples;
        send(s[4*i +: 4], (i == frames[f].n - 1));
      end
      check_result(frames[f].name, frames[f].exp_max, frames[f].exp_min,
                   frames[f].exp_mcnt, frames[f].exp_scnt);
      tick();
      release_result(frames[f].name);
      tick();
    end

    // Back-pressure with idle gaps: frame 4,1,12,4 with bubbles on in_valid.
    send(4'd4, 1'b0);
    tick();
    send(4'd1, 1'b0);
    tick();
    tick();
    send(4'd12, 1'b0);
    send(4'd4, 1'b1);
    check_result("bp", 4'd12, 4'd1, 4'd1, 4'd4);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = (c % 2 == 0) ? 4'd15 : 4'd0;
      in_last = c[0];
      tick();
      check_result("bp_hold", 4'd12, 4'd1, 4'd1, 4'd4);
    end
    in_data = 4'd15;
    in_last = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_valid_drop", int'(out_valid), 0);
    check("bp_state_idle", int'(dbg_state), 0);
    send(4'd7, 1'b1);
    check_result("bp_next", 4'd7, 4'd7, 4'd1, 4'd1);
    release_result("bp_next");

    // Reset mid-frame.
    send(4'd8, 1'b0);
    send(4'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_max", int'(max_out), 0);
    check("rmid_min", int'(min_out), 0);
    check("rmid_sample_count", int'(sample_count), 0);
    check("rmid_state", int'(dbg_state), 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset during HOLD.
    send(4'd5, 1'b1);
    check("rhold_pre_valid", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rhold_valid", int'(out_valid), 0);
    check("rhold_max", int'(max_out), 0);
    check("rhold_max_count", int'(max_count), 0);
    check("rhold_in_ready", int'(in_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    check("rhold_stays_idle", int'(out_valid), 0);

    // Fresh frame after reset: no carry-over.
    send(4'd6, 1'b0);
    send(4'd6, 1'b1);
    check_result("post_rst", 4'd6, 4'd6, 4'd2, 4'd2);
    release_result("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/four_bit_max_tracker.md
# four_bit_max_tracker

Frame-based statistics stage placed directly downstream of `four_bit_comparator`. It accepts a stream of 4-bit unsigned samples over a valid/ready handshake and feeds each sample into two comparator instances, one against the running maximum and one against the running minimum. It consumes the `o_gt`/`o_eq` results to update the frame's maximum, minimum, maximum-occurrence count and sample count. At frame end it presents the results on a held valid/ready output.

## Interface
- `CNT_W`, default 4: width of `max_count` and `sample_count`; both counters saturate at 2^CNT_W-1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_last` are valid this cycle.
- `in_data`  in  4  unsigned sample.
- `in_last`  in  1  marks the final sample of the frame.
- `in_ready`  out  1  block can accept a sample this cycle.
- `out_valid`  out  1  frame result is valid and held.
- `out_ready`  in  1  downstream accepts the result.
- `max_out`  out  4  largest sample in the frame.
- `min_out`  out  4  smallest sample in the frame.
- `max_count`  out  CNT_W  number of samples equal to `max_out`, saturating.
- `sample_count`  out  CNT_W  samples in the frame, saturating.

## Operation
- **Accept rule:** a sample is accepted on a rising edge where `in_valid & in_ready` = 1.
- **State machine:** 3 states, encoded in registers.
  - IDLE: no frame open.
  - ACCUM: frame open, at least one sample accepted.
  - HOLD: result presented.
- `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD. It is a combinational decode of the state register only.
- **Comparator use:**
  - Comparator A gets x=`in_data`, y=current max.
  - Comparator B gets x=current min, y=`in_data`.
  - Comparator results are used only in ACCUM.
- **First accepted sample (in IDLE):** max=min=`in_data`, `max_count`=1, `sample_count`=1. Comparator outputs are ignored.
- **Later accepted samples (in ACCUM):**
  - A.`o_gt`: max←`in_data`, `max_count`←1.
  - A.`o_eq`: `max_count`←`max_count`+1, saturating.
  - Otherwise the max and `max_count` are unchanged.
  - B.`o_gt`: min←`in_data`. Otherwise the min is unchanged.
  - `sample_count`←+1, saturating at 2^CNT_W-1.
- **Transitions:**
  - IDLE→ACCUM on an accepted sample with `in_last`=0.
  - IDLE→HOLD on an accepted sample with `in_last`=1 (single-sample frame).
  - ACCUM→HOLD on an accepted sample with `in_last`=1. That sample is included in the results.
  - HOLD→IDLE on a rising edge with `out_valid & out_ready`.
  - All other cases: stay in the current state.
- **Outputs:** `out_valid` = (state==HOLD). `max_out`, `min_out`, `max_count` and `sample_count` are registers. They are stable throughout HOLD and are meaningful only while `out_valid`=1.
- **Data in non-accepting cycles:** `in_data`/`in_last` are ignored whenever `in_valid`=0 or the state is HOLD.
- **Saturation:** `max_count` and `sample_count` never wrap. At all-ones they stay all-ones.

## Timing
- **Reset:** `rst` high forces the following asynchronously: state=IDLE, `out_valid`=0, `max_out`=0, `min_out`=0, `max_count`=0, `sample_count`=0. Consequently `in_ready`=1.
  - While `rst` is high, no sample is accepted, even if `in_valid`=1.
  - Reset mid-frame or in HOLD discards the frame. No result is produced.
- **Latency:** `out_valid` rises in the cycle after the edge that accepts the `in_last` sample (1 cycle).
- **Output hold:** `out_valid` stays high with constant data until `out_ready` is sampled high. It falls in the cycle after that handshake edge.
- **Frame throughput:** minimum gap between frames is the HOLD time, at least 1 cycle. `in_ready` is 0 for every cycle in which `out_valid` is 1. Thus an input accept and an output accept never happen on the same edge.
- **Back-pressure:** `out_ready`=0 holds HOLD indefinitely. `in_valid` held during that time is not consumed.
- **Comparator path:** fully combinational within one cycle, from the `in_data` and max/min registers to the next-state logic.

## Test plan
- **Basic frame:** 5,9,2,9,7 (7 with `in_last`) → one cycle later `out_valid`=1, `max_out`=9, `min_out`=2, `max_count`=2, `sample_count`=5. `in_ready`=0 until `out_ready`.
- **Single-sample frame:** 4'b1010 with `in_last` from IDLE → `max_out`=`min_out`=10, `max_count`=1, `sample_count`=1.
- **Back-pressure and idle gaps:** `in_valid` toggles, and `out_ready`=0 for 6 cycles in HOLD.
  - Outputs stay unchanged during HOLD.
  - Samples offered during HOLD are not counted.
  - After the `out_ready` pulse, `out_valid`=0 on the next cycle, and the next frame starts fresh.
- **Saturation:** 20 samples, all 15 (CNT_W=4) → `max_out`=`min_out`=15, `max_count`=15, `sample_count`=15. No wrap to 0–4.
- **Boundary values:** frame 0,15,0,15 → `max_out`=15, `min_out`=0, `max_count`=2. Then frame 3,1,2: min updates only on strictly smaller samples; result `max_out`=3, `max_count`=1, `min_out`=1.
- **Reset mid-operation:** assert `rst` after 2 samples of a frame, and again during HOLD.
  - All outputs go to 0 immediately, and `out_valid`=0.
  - The following frame 6,6 gives `max_count`=2, `sample_count`=2, with no carry-over.
